fetch_queue: RTL

// - Decoupled instruction-fetch front end for the rv32I multicycle pipeline. It issues pipelined reads up to DEPTH deep.
// - It buffers returned words in an in-order queue and hands them to decode over the ReadyToSend/ReadyToRcv handshake.
// - It supports PC redirect (branch or interrupt) with flush, and discards stale in-flight responses.

---
 rtl/rv_pipe_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/fetch_queue.sv | 132 +++++++++++++
 3 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the rv32I pipeline front end: FSM encodings,
// instruction length and a constant-friendly clog2.
package rv_pipe_pkg;

  localparam logic FQ_IDLE = 1'b0;
  localparam logic FQ_RUN  = 1'b1;

  localparam int ILEN = 4;

  typedef enum logic {
    ST_IDLE = FQ_IDLE,
    ST_RUN  = FQ_RUN
  } fq_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous first-word-fall-through FIFO held in flops; the head word is
// always visible on rdata_o, with count_o distinguishing full from empty.
module fetch_fifo
  import rv_pipe_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  localparam int CW   = clog2(DEPTH + 1),
  localparam int PW   = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic [CW-1:0] count_o
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push, do_pop;

  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign do_pop  = pop_i & (count_q != '0);
  assign do_push = push_i & ((count_q != CW'(DEPTH)) | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Decoupled fetch front end: credit-limited pipelined reads, in-order return
// queue toward decode, and redirect with discard of stale in-flight responses.
module fetch_queue
  import rv_pipe_pkg::*;
#(
  parameter int                XLEN     = 32,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] START_PC = '0,
  localparam int               CW       = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              startSig,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              mem_reqReady,
  output logic              mem_readEn,
  output logic [ADDR_W-1:0] mem_read_addr,
  input  logic [XLEN-1:0]   mem_read_data,
  input  logic              readFin,
  input  logic              nextPipReadyToRcv,
  output logic              curPipReadyToSend,
  output logic [XLEN-1:0]   fetch_data,
  output logic [ADDR_W-1:0] fetch_cur_pc,
  output logic [ADDR_W-1:0] fetch_nxt_pc,
  output logic [CW-1:0]     queue_count
);

  localparam int FW = XLEN + ADDR_W;

  fq_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic [CW-1:0]     drop_q, drop_d;

  logic              redir;
  logic [ADDR_W-1:0] redir_target;
  logic              credit_ok;
  logic              issue;
  logic              resp_keep;
  logic              pop;
  logic              head_valid;
  logic [CW-1:0]     fifo_count;
  logic [FW-1:0]     fifo_rdata;

  // startSig while running behaves exactly like a redirect to START_PC.
  assign redir        = redirect_valid | (startSig & (state_q == ST_RUN));
  assign redir_target = redirect_valid ? redirect_pc : START_PC;

  assign credit_ok  = ({1'b0, fifo_count} + {1'b0, inflight_q}) < (CW + 1)'(DEPTH);
  assign mem_readEn = (state_q == ST_RUN) & ~redir & credit_ok;
  assign issue      = mem_readEn & mem_reqReady;

  // resp_pc_q is the PC of the next response that will be kept; dropped
  // responses belong to an older fetch stream and never advance it.
  assign resp_keep = readFin & ~redir & (drop_q == '0) & (state_q == ST_RUN);

  assign head_valid        = (fifo_count != '0);
  assign curPipReadyToSend = head_valid & ~redir;
  assign pop               = curPipReadyToSend & nextPipReadyToRcv;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    inflight_d = inflight_q + CW'(issue) - CW'(readFin);
    case (state_q)
      ST_IDLE: begin
        if (redirect_valid || startSig) begin
          state_d   = ST_RUN;
          pc_d      = redir_target;
          resp_pc_d = redir_target;
          drop_d    = '0;
        end
      end
      ST_RUN: begin
        if (redir) begin
          pc_d      = redir_target;
          resp_pc_d = redir_target;
          drop_d    = inflight_q - CW'(readFin);
        end else begin
          if (issue) pc_d = pc_q + ADDR_W'(ILEN);
          if (readFin) begin
            if (drop_q != '0) drop_d = drop_q - CW'(1);
            else              resp_pc_d = resp_pc_q + ADDR_W'(ILEN);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= START_PC;
      resp_pc_q  <= START_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (resp_keep),
    .pop_i   (pop),
    .flush_i (redir),
    .wdata_i ({mem_read_data, resp_pc_q}),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count)
  );

  assign mem_read_addr = pc_q;
  assign queue_count   = fifo_count;
  assign fetch_data    = head_valid ? fifo_rdata[FW-1 -: XLEN] : '0;
  assign fetch_cur_pc  = head_valid ? fifo_rdata[ADDR_W-1:0] : '0;
  assign fetch_nxt_pc  = head_valid ? (fifo_rdata[ADDR_W-1:0] + ADDR_W'(ILEN)) : '0;

endmodule
